// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and width helpers for the core's inter-stage buffers.
//   d2x_t / x2m_t / m2w_t : packed payloads carried by each pipe_stage_buf
//                           instance (set WIDTH = $bits(<type>)).
//   cnt_width(depth)      : bits needed to hold an occupancy of 0..depth.
//   ptr_width(depth)      : bits needed to index depth entries (min 1).
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rd_we;
  } d2x_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
  } x2m_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        rd_we;
  } m2w_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// pipe_stage_mem: DEPTH x WIDTH register array backing a pipe_stage_buf.
//   clk   : clock, write on posedge
//   we    : write enable
//   waddr : write index (0..DEPTH-1)
//   wdata : write payload
//   raddr : read index (0..DEPTH-1)
//   rdata : asynchronous read of entry raddr
// Contents are not reset; the owning buffer tracks which entries are live.
module pipe_stage_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // One independently enabled register per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  // Zero-latency read so the head entry is visible in the cycle after its write.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready inter-stage buffer holding up to DEPTH beats.
//   clk, rst          : clock and synchronous active-high reset
//   flush             : drop all stored beats and the incoming beat this cycle
//   s_valid/s_ready/s_data : upstream handshake and payload
//   m_valid/m_ready/m_data : downstream handshake and payload
//   count, full, empty     : occupancy status
// BYPASS=1 lets a beat reach m_data in the cycle it arrives while empty.
// s_ready never depends on m_ready, so no combinational ready path crosses
// the stage; DEPTH=1 therefore gives one beat every two cycles.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 0,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_data;
  logic             bypass_take;
  logic             push;
  logic             pop;

  // Modulo-DEPTH increment that also works for non-power-of-2 depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign s_ready = ~full & ~flush & ~rst;

  always_comb begin
    m_valid     = ~empty & ~flush;
    m_data      = head_data;
    bypass_take = 1'b0;
    if (BYPASS != 0) begin
      m_valid = (~empty | s_valid) & ~flush;
      if (empty) begin
        m_data = s_data;
        // A beat handed straight through is never written to storage.
        bypass_take = s_valid & m_ready & ~flush;
      end
    end
    push = s_valid & s_ready & ~bypass_take;
    pop  = m_valid & m_ready & ~empty;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH)) else $error("count above DEPTH");
      assert (!(full && empty)) else $error("full and empty together");
      assert (!(push && full)) else $error("enqueue while full");
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf across four configurations:
//   a: DEPTH=2 BYPASS=0, b: DEPTH=3 BYPASS=0, c: DEPTH=2 BYPASS=1,
//   d: DEPTH=1 BYPASS=0 (own reset for the mid-stream reset case).
module tb_pipe_stage_buf;

  logic clk;
  logic rst;
  logic rst_d;

  logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_full, a_empty;
  logic [7:0] a_s_data, a_m_data;
  logic [1:0] a_count;
  logic       b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_full, b_empty;
  logic [7:0] b_s_data, b_m_data;
  logic [1:0] b_count;
  logic       c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready, c_full, c_empty;
  logic [7:0] c_s_data, c_m_data;
  logic [1:0] c_count;
  logic       d_flush, d_s_valid, d_s_ready, d_m_valid, d_m_ready, d_full, d_empty;
  logic [7:0] d_s_data, d_m_data;
  logic [0:0] d_count;

  int total;
  int bad;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .BYPASS(0)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .count(a_count), .full(a_full), .empty(a_empty));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .count(b_count), .full(b_full), .empty(b_empty));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .count(c_count), .full(c_full), .empty(c_empty));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(1), .BYPASS(0)) dut_d (
    .clk(clk), .rst(rst_d), .flush(d_flush),
    .s_valid(d_s_valid), .s_ready(d_s_ready), .s_data(d_s_data),
    .m_valid(d_m_valid), .m_ready(d_m_ready), .m_data(d_m_data),
    .count(d_count), .full(d_full), .empty(d_empty));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    int in_i, out_n, mc, n_deq;
    logic enq, deq, acc;

    total = 0;
    bad   = 0;
    rst = 1'b1; rst_d = 1'b1;
    {a_flush, a_s_valid, a_m_ready} = '0; a_s_data = '0;
    {b_flush, b_s_valid, b_m_ready} = '0; b_s_data = '0;
    {c_flush, c_s_valid, c_m_ready} = '0; c_s_data = '0;
    {d_flush, d_s_valid, d_m_ready} = '0; d_s_data = '0;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_a_srdy", a_s_ready, 0);
    chk("rst_b_srdy", b_s_ready, 0);
    rst = 1'b0; rst_d = 1'b0;
    #1;
    chk("rst_a_count", a_count, 0);
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_full",  a_full,  0);
    chk("rst_a_mvalid", a_m_valid, 0);
    chk("rst_a_srdy_after", a_s_ready, 1);

    // ---------------- a: back-to-back streaming, DEPTH=2 ----------------
    a_m_ready = 1'b1; a_s_valid = 1'b1; a_s_data = 8'h11;
    tick();
    chk("a_data0", a_m_data, 8'h11);
    chk("a_cnt0", a_count, 1);
    a_s_data = 8'h22;
    tick();
    chk("a_data1", a_m_data, 8'h22);
    chk("a_cnt1", a_count, 1);
    a_s_data = 8'h33;
    tick();
    chk("a_data2", a_m_data, 8'h33);
    chk("a_cnt2", a_count, 1);
    a_s_valid = 1'b0;
    tick();
    chk("a_empty_end", a_empty, 1);
    chk("a_mvalid_end", a_m_valid, 0);

    // ---------------- b: fill DEPTH=3, then drain ----------------
    b_s_valid = 1'b1;
    b_s_data = 8'h0A; tick();
    b_s_data = 8'h0B; tick();
    b_s_data = 8'h0C; tick();
    b_s_valid = 1'b0;
    #1;
    chk("b_full", b_full, 1);
    chk("b_srdy_full", b_s_ready, 0);
    chk("b_cnt3", b_count, 3);
    b_m_ready = 1'b1;
    chk("b_out0", b_m_data, 8'h0A); tick();
    chk("b_out1", b_m_data, 8'h0B); tick();
    chk("b_out2", b_m_data, 8'h0C); tick();
    chk("b_drained", b_empty, 1);

    // ---------------- b: wrap with random stalls ----------------
    in_i = 0; out_n = 0; mc = 0;
    for (int cyc = 0; cyc < 200 && out_n < 10; cyc++) begin
      b_m_ready = 1'($urandom_range(0, 1));
      b_s_valid = (in_i < 10);
      b_s_data  = 8'h40 + 8'(in_i);
      #1;
      chk("wrap_cnt", b_count, mc);
      chk("wrap_srdy", b_s_ready, (mc != 3));
      chk("wrap_mvalid", b_m_valid, (mc != 0));
      enq = b_s_valid && b_s_ready;
      deq = b_m_valid && b_m_ready;
      if (deq) begin
        exp_v = exp_q.pop_front();
        chk("wrap_data", b_m_data, exp_v);
        out_n++;
      end
      if (enq) begin
        exp_q.push_back(b_s_data);
        in_i++;
      end
      mc = mc + int'(enq) - int'(deq);
      tick();
    end
    chk("wrap_beats", out_n, 10);
    b_s_valid = 1'b0;

    // ---------------- b: flush with two stored beats ----------------
    b_m_ready = 1'b0; b_s_valid = 1'b1;
    b_s_data = 8'h01; tick();
    b_s_data = 8'h02; tick();
    chk("fl_cnt_pre", b_count, 2);
    b_flush = 1'b1; b_s_data = 8'h55;
    #1;
    chk("fl_srdy", b_s_ready, 0);
    chk("fl_mvalid", b_m_valid, 0);
    tick();
    b_flush = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b1;
    #1;
    chk("fl_cnt", b_count, 0);
    chk("fl_empty", b_empty, 1);
    for (int i = 0; i < 3; i++) begin
      chk("fl_no55", b_m_valid, 0);
      tick();
    end
    b_s_valid = 1'b1; b_s_data = 8'h66;
    tick();
    b_s_valid = 1'b0;
    #1;
    chk("fl_after_valid", b_m_valid, 1);
    chk("fl_after_data", b_m_data, 8'h66);
    tick();
    chk("fl_after_empty", b_empty, 1);

    // ---------------- c: bypass ----------------
    c_s_valid = 1'b1; c_s_data = 8'h77; c_m_ready = 1'b1;
    #1;
    chk("byp_mvalid", c_m_valid, 1);
    chk("byp_data", c_m_data, 8'h77);
    tick();
    chk("byp_cnt", c_count, 0);
    c_s_data = 8'h78; c_m_ready = 1'b0;
    #1;
    chk("byp_stall_data", c_m_data, 8'h78);
    tick();
    c_s_valid = 1'b0;
    #1;
    chk("byp_stored_cnt", c_count, 1);
    chk("byp_stored_data", c_m_data, 8'h78);
    c_m_ready = 1'b1;
    tick();
    chk("byp_drained", c_count, 0);

    // ---------------- d: DEPTH=1 throughput, mid-stream reset ----------------
    d_s_valid = 1'b1; d_m_ready = 1'b1; d_s_data = 8'h90;
    exp_v = 8'h90; n_deq = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      acc = d_s_valid && d_s_ready;
      if (d_m_valid && d_m_ready) begin
        chk("d1_data", d_m_data, exp_v);
        exp_v++;
        n_deq++;
      end
      tick();
      if (acc) d_s_data++;
    end
    chk("d1_rate", n_deq, 4);
    tick();
    chk("d1_cnt_pre_rst", d_count, 1);
    rst_d = 1'b1;
    #1;
    chk("d1_srdy_in_rst", d_s_ready, 0);
    tick();
    chk("d1_rst_mvalid", d_m_valid, 0);
    chk("d1_rst_cnt", d_count, 0);
    chk("d1_rst_srdy", d_s_ready, 0);
    rst_d = 1'b0;
    #1;
    chk("d1_srdy_post", d_s_ready, 1);
    tick();
    chk("d1_cnt_post", d_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised valid/ready pipeline stage buffer that replaces the single-entry inter-stage bus registers of the core (fetch→decode, decode→execute, execute→memory, memory→writeback). It holds up to DEPTH payload beats in a circular buffer. It adds a synchronous flush for branch and trap redirect, an optional zero-latency bypass, and an occupancy output. Payload is an opaque packed vector; each stage concatenates its control and data fields into it.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, number of storage entries (>=1); 1 reproduces the legacy single-register stage
BYPASS, 0, 1 = a beat may pass s_data→m_data in the same cycle when the buffer is empty
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)

Ports:
clk      in   1       clock; all state updates on posedge
rst      in   1       synchronous, active-high reset
flush    in   1       discard all stored beats and the incoming beat this cycle
s_valid  in   1       upstream beat valid
s_ready  out  1       buffer can accept a beat
s_data   in   WIDTH   upstream payload
m_valid  out  1       downstream beat valid
m_ready  in   1       downstream accepts
m_data   out  WIDTH   downstream payload (head entry, or s_data when bypassing)
count    out  CNT_W   entries currently stored
full     out  1       count == DEPTH
empty    out  1       count == 0

Behaviour:
- Reset values (rst sampled high at posedge):
  - count=0, rd_ptr=0, wr_ptr=0, empty=1, full=0.
  - m_valid=0; s_ready=0 while rst is high.
  - Storage contents are don't-care; m_data is don't-care while m_valid=0.
- Handshakes:
  - Enqueue occurs when s_valid & s_ready. Dequeue occurs when m_valid & m_ready.
  - s_ready = ~full & ~flush & ~rst. It does not depend on m_ready, so no combinational ready path exists through the stage.
  - m_valid = ~empty & ~flush. With BYPASS=1 it is (~empty | s_valid) & ~flush.
  - m_data = mem[rd_ptr] when not empty; with BYPASS=1 and empty, m_data = s_data.
  - Once m_valid is asserted, m_data stays stable until the dequeue, unless a flush occurs.
- Latency:
  - BYPASS=0: 1 cycle from enqueue to m_valid.
  - BYPASS=1 and empty: 0 cycles. If m_ready is also high, the beat is consumed and never stored (count unchanged). If m_ready is low, the beat is stored normally.
- Throughput: DEPTH>=2 sustains 1 beat/cycle. DEPTH=1 sustains 1 beat per 2 cycles, matching the legacy behaviour.
- Simultaneous enqueue and dequeue:
  - When not empty: write at wr_ptr, read at rd_ptr, count unchanged.
  - When full: enqueue is blocked (s_ready=0) even if m_ready=1. The slot frees on the next cycle.
- Pointer wrap: pointers increment modulo DEPTH. Arbitrary DEPTH (not only powers of 2) is supported via explicit compare-and-reset to 0.
- Flush:
  - On a posedge with flush=1: count←0 and rd_ptr←wr_ptr←0.
  - The incoming beat is dropped, no dequeue is signalled, and flush takes priority over enqueue and dequeue.
  - Flush while empty is a no-op apart from forcing s_ready=0 for that cycle.
- rst takes priority over flush. Reset asserted mid-stream discards all beats. The first enqueue is possible in the cycle after rst deasserts.
- Width rule: count increments and decrements in CNT_W bits and never exceeds DEPTH. The checker asserts count<=DEPTH, ~(full & empty), and no enqueue when full.

Decomposition:
- Package pipe_pkg holds:
  - packed payload struct typedefs per stage (d2x_t, x2m_t, m2w_t), so each instance sets WIDTH=$bits(type);
  - the clog2-based width helper.
- One sub-module, pipe_stage_mem: a DEPTH×WIDTH register array with one write port (we, waddr, wdata) and one async read port. The pointer, count and handshake logic stays in pipe_stage_buf.

Test Plan:
- DEPTH=2, BYPASS=0, m_ready=1: push 0x11, 0x22, 0x33 on consecutive cycles → m_data shows 0x11, 0x22, 0x33 one cycle later, back-to-back; count never exceeds 1.
- DEPTH=3, m_ready=0: push 0xA, 0xB, 0xC → full=1, s_ready=0, count=3. Then raise m_ready for 3 cycles → 0xA, 0xB, 0xC out in order, empty=1.
- DEPTH=3 wrap: 10 enqueue/dequeue pairs with random m_ready stalls → output sequence equals input sequence; a pointer wraps at least 3 times.
- Flush with count=2 while s_valid=1 (data 0x55) → next cycle count=0, m_valid=0, and 0x55 never appears at m_data.
- BYPASS=1, empty, s_valid=1, data 0x77, m_ready=1 → m_valid=1 and m_data=0x77 in the same cycle; count stays 0.
- DEPTH=1, continuous s_valid and m_ready → one beat every 2 cycles. Assert rst mid-stream → m_valid=0 and count=0 next cycle, with s_ready=0 during reset.
